guess_arbiter: RTL and testbench

- Round-robin scheduler that shares the single hangman guess datapath (letter compare/controller) among NP player ports.
- Accepts letter requests from players and filters invalid and duplicate letters locally.
- Issues one guess at a time to the game controller in the 6-bit strobe+letter format, waits for completion, then returns hit/miss to the requesting player.
- Sits between player input pins and the game controller's chip_input.

---
 rtl/guess_arbiter.sv | 111 +++++++++++
 tb/tb_guess_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/guess_arbiter.sv
// guess_arbiter: round-robin scheduler sharing one hangman guess datapath among NP player ports
module guess_arbiter #(
    parameter int NP       = 4,
    parameter int WAIT_MAX = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_game,
    input  logic [NP-1:0]         player_req,
    input  logic [5*NP-1:0]       player_letter,
    output logic [NP-1:0]         player_ack,
    output logic                  rsp_hit,
    output logic                  rsp_dup,
    output logic                  rsp_err,
    output logic [5:0]            guess_out,
    input  logic                  game_ready,
    input  logic                  game_done,
    input  logic                  game_hit,
    input  logic                  game_over,
    output logic [$clog2(NP)-1:0] cur_player
);
    localparam int PW = $clog2(NP);
    localparam int TW = $clog2(WAIT_MAX);
    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, RESP, OVER} state_t;
    state_t        state, state_nx;
    logic [PW-1:0] ptr, win, gnt_idx;
    logic [4:0]    letter, gnt_letter;
    logic [25:0]   mask;
    logic [31:0]   mask_ext;
    logic [TW-1:0] timer;
    logic          hit, dup, err, is_dup, timeout, go;
    assign go         = |player_req && game_ready && !game_over;
    assign mask_ext   = {6'd0, mask};
    assign is_dup     = (letter > 5'd25) || mask_ext[letter];
    assign timeout    = timer == TW'(WAIT_MAX - 2);
    assign gnt_letter = player_letter[5*int'(gnt_idx) +: 5];
    // scan downwards so the requester closest at/after ptr is the last to win
    always_comb begin
        gnt_idx = ptr;
        for (int i = NP - 1; i >= 0; i--) begin
            if (player_req[(int'(ptr) + i) % NP]) gnt_idx = PW'((int'(ptr) + i) % NP);
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = game_over ? OVER : (|player_req && game_ready) ? ARB : IDLE;
            ARB:     state_nx = is_dup ? RESP : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (game_done || timeout) ? RESP : WAIT;
            RESP:    state_nx = IDLE;
            OVER:    state_nx = OVER;
            default: state_nx = IDLE;
        endcase
        if (new_game) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            win        <= '0;
            cur_player <= '0;
            letter     <= '0;
            mask       <= '0;
            timer      <= '0;
            hit        <= 1'b0;
            dup        <= 1'b0;
            err        <= 1'b0;
        end else if (new_game) begin
            ptr        <= '0;
            cur_player <= '0;
            mask       <= '0;
            hit        <= 1'b0;
            dup        <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    win        <= gnt_idx;
                    cur_player <= gnt_idx;
                    letter     <= gnt_letter;
                    ptr        <= (gnt_idx == PW'(NP - 1)) ? '0 : gnt_idx + 1'b1;
                    hit        <= 1'b0;
                    dup        <= 1'b0;
                    err        <= 1'b0;
                end
                ARB:   dup <= is_dup;
                ISSUE: begin
                    mask  <= mask | (26'd1 << letter);
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (game_done)    hit <= game_hit;
                    else if (timeout) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_comb begin
        guess_out  = (state == ISSUE) ? {1'b1, letter} : 6'd0;
        player_ack = (state == RESP) ? NP'(1) << win : '0;
        rsp_hit    = (state == RESP) && hit;
        rsp_dup    = (state == RESP) && dup;
        rsp_err    = (state == RESP) && err;
    end
endmodule

// File: tb/tb_guess_arbiter.sv
// tb_guess_arbiter: directed scenarios plus random traffic against a cycle-timeline model of the arbiter
module tb_guess_arbiter;
    localparam int NP = 4;
    localparam int WAIT_MAX = 32;
    logic clk = 0, reset = 0, new_game = 0, game_ready = 0, game_done = 0, game_hit = 0, game_over = 0;
    logic [NP-1:0]   player_req = '0;
    logic [NP-1:0]   player_ack;
    logic [5*NP-1:0] player_letter = '0;
    logic            rsp_hit, rsp_dup, rsp_err;
    logic [5:0]      guess_out;
    logic [1:0]      cur_player;

    always #5 clk = ~clk;

    guess_arbiter #(.NP(NP), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .player_req(player_req), .player_letter(player_letter), .player_ack(player_ack),
        .rsp_hit(rsp_hit), .rsp_dup(rsp_dup), .rsp_err(rsp_err), .guess_out(guess_out),
        .game_ready(game_ready), .game_done(game_done), .game_hit(game_hit),
        .game_over(game_over), .cur_player(cur_player)
    );

    int n_vec = 0, n_bad = 0;
    // model: a guess is a timeline -- granted at cycle m_t, strobe at m_t+1, answer at cycle m_r
    int cyc = 0, m_t = 0, m_r = -1, m_win = 0, m_let = 0, m_ptr = 0, m_cur = 0;
    bit busy = 0, over = 0, m_dup = 0, m_hit = 0, m_err = 0;
    bit [31:0] m_mask = '0;
    int ctl_k = -1, ctl_delay = 0, strobes = 0, s0 = 0, a0 = 0;
    bit ctl_rand = 0, ctl_hit_val = 0, raised = 0;
    int ack_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear;
        busy = 0; over = 0; m_mask = '0; m_ptr = 0; m_cur = 0;
    endtask

    task automatic model_tick;
        cyc++;
        if (!reset) model_clear();
        else if (new_game) model_clear();
        else if (busy) begin
            if (cyc - 1 == m_r) busy = 0;
            else if (!m_dup && m_r < 0) begin
                if (cyc == m_t + 2) m_mask[m_let] = 1'b1;
                if (cyc - 1 >= m_t + 2 && game_done) begin m_r = cyc; m_hit = game_hit; end
                else if (cyc == m_t + 1 + WAIT_MAX) begin m_r = cyc; m_err = 1; end
            end
        end else if (!over) begin
            if (game_over) over = 1;
            else if (player_req != 0 && game_ready) begin
                for (int i = NP - 1; i >= 0; i--) if (player_req[(m_ptr + i) % NP]) m_win = (m_ptr + i) % NP;
                m_let = int'(player_letter[m_win*5 +: 5]);
                m_cur = m_win; m_ptr = (m_win + 1) % NP; m_t = cyc; busy = 1; m_hit = 0; m_err = 0;
                m_dup = (m_let > 25) || m_mask[m_let];
                m_r = m_dup ? cyc + 1 : -1;
            end
        end
    endtask

    function automatic logic [31:0] outs();
        return {17'd0, guess_out, player_ack, rsp_hit, rsp_dup, rsp_err, cur_player};
    endfunction

    task automatic step;
        logic [5:0] eg;
        logic [3:0] ea;
        bit an;
        @(posedge clk); #1;
        model_tick();
        an = busy && cyc == m_r;
        eg = (busy && !m_dup && cyc == m_t + 1) ? {1'b1, 5'(m_let)} : 6'd0;
        ea = an ? 4'(1 << m_win) : 4'd0;
        chk("cycle", outs(), {17'd0, eg, ea, an && m_hit, an && m_dup, an && m_err, 2'(m_cur)});
        game_done = 0;
        if (ctl_k >= 0) ctl_k++;
        if (guess_out[5]) begin
            strobes++; ctl_k = 0;
            if (ctl_rand) begin ctl_delay = $urandom_range(1, 36); ctl_hit_val = 1'($urandom_range(0, 1)); end
        end
        if (ctl_delay > 0 && ctl_k == ctl_delay) begin game_done = 1; game_hit = ctl_hit_val; ctl_k = -1; end
        for (int i = 0; i < NP; i++) if (player_ack[i]) begin ack_q.push_back(i); player_req[i] = 0; end
    endtask

    task automatic set_req(input int i, input int l);
        player_letter[5*i +: 5] = 5'(l);
        player_req[i] = 1'b1;
    endtask

    task automatic wait_acks(input int n, input string name);
        int k = 0;
        while (ack_q.size() < n && k < 200) begin step(); k++; end
        chk(name, ack_q.size(), n);
    endtask

    initial begin
        game_ready = 1;
        repeat (3) step();
        chk("reset_outputs", outs(), 0);
        reset = 1; step();
        // p1 guesses 'n'; controller answers hit three cycles after the strobe
        ctl_delay = 3; ctl_hit_val = 1;
        set_req(1, 13);
        step(); step();
        chk("p1_strobe", guess_out, 6'b101101);
        repeat (4) step();
        chk("p1_ack_hit", {player_ack, rsp_hit}, {4'b0010, 1'b1});
        // asynchronous reset in the middle of a wait
        step(); ctl_delay = 0; set_req(2, 5);
        repeat (4) step();
        reset = 0; model_clear(); player_req = '0; #1;
        chk("reset_async", outs(), 0);
        step(); reset = 1; ctl_delay = 2; ack_q.delete();
        set_req(0, 13);
        step(); step();
        chk("post_reset_strobe", guess_out, 6'b101101);
        wait_acks(1, "post_reset_ack");
        // round-robin order after a fresh game
        new_game = 1; step(); new_game = 0; ack_q.delete(); raised = 0;
        set_req(0, 0); set_req(2, 2); set_req(3, 3);
        for (int k = 0; k < 300 && ack_q.size() < 4; k++) begin
            step();
            if (ack_q.size() == 2 && !raised) begin set_req(1, 1); raised = 1; end
        end
        chk("rr_order", 32'((ack_q[0] << 12) | (ack_q[1] << 8) | (ack_q[2] << 4) | ack_q[3]), 32'h0231);
        chk("rr_cur", cur_player, 1);
        // duplicate and invalid letters
        step(); ack_q.delete(); set_req(0, 4);
        wait_acks(1, "e_first_ack");
        s0 = strobes;
        step(); set_req(2, 4); step(); step();
        chk("dup_e", {player_ack, rsp_dup, rsp_hit, rsp_err}, {4'b0100, 3'b100});
        step(); set_req(1, 27); step(); step();
        chk("dup_27", {player_ack, rsp_dup}, {4'b0010, 1'b1});
        chk("dup_no_strobe", strobes, s0);
        // controller timeout, then the same letter is a duplicate
        step(); ctl_delay = 0; set_req(3, 7); step(); step();
        chk("to_strobe", guess_out, 6'b100111);
        repeat (WAIT_MAX) step();
        chk("timeout_err", {player_ack, rsp_err, rsp_hit}, {4'b1000, 2'b10});
        step(); set_req(3, 7); step(); step();
        chk("to_dup", {player_ack, rsp_dup}, {4'b1000, 1'b1});
        // game over blocks grants until new_game; 'a' becomes usable again
        step(); ctl_delay = 2; game_over = 1; set_req(0, 0); a0 = ack_q.size();
        repeat (50) step();
        chk("over_no_ack", ack_q.size(), a0);
        new_game = 1; game_over = 0; step(); new_game = 0;
        step(); step();
        chk("ng_strobe_a", guess_out, 6'b100000);
        chk("ng_cur", cur_player, 0);
        wait_acks(a0 + 1, "ng_ack");
        // random traffic
        ctl_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            new_game = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 299) == 0) game_over = 1;
            if (new_game) game_over = 0;
            game_ready = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) begin game_done = 1; game_hit = 1'($urandom_range(0, 1)); end
            for (int i = 0; i < NP; i++) begin
                if (!player_req[i] && $urandom_range(0, 7) == 0) set_req(i, $urandom_range(0, 31));
                else if (player_req[i] && $urandom_range(0, 63) == 0) player_req[i] = 0;
            end
        end
        new_game = 0; game_over = 0; player_req = '0;
        repeat (WAIT_MAX + 8) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
